// File: rtl/logic_basic_queue_memory_pipelined_if.sv
// Write/read bus of the pipelined queue memory.
//   master : drives the write port (enable, byte mask, pointer, data) and the
//            read request (enable, pointer); receives read_valid/read_data.
//   slave  : the storage element; receives requests, returns read results.
// BYTES must equal DATA_WIDTH/BYTE_WIDTH of the attached memory.
interface logic_basic_queue_memory_pipelined_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int BYTES         = 1
);
  logic                     write_enable;
  logic [BYTES-1:0]         write_byte_enable;
  logic [ADDRESS_WIDTH-1:0] write_pointer;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     read_enable;
  logic [ADDRESS_WIDTH-1:0] read_pointer;
  logic                     read_valid;
  logic [DATA_WIDTH-1:0]    read_data;

  modport master (
    output write_enable, write_byte_enable, write_pointer, write_data,
    output read_enable, read_pointer,
    input  read_valid, read_data
  );

  modport slave (
    input  write_enable, write_byte_enable, write_pointer, write_data,
    input  read_enable, read_pointer,
    output read_valid, read_data
  );
endinterface

// File: rtl/logic_basic_queue_memory_pipelined.sv
// Simple dual-port queue storage with per-byte write enables, a registered
// read pipeline of READ_LATENCY stages carrying a valid bit alongside the
// data, and optional read-during-write bypass at stage 1.
// Ports:
//   aclk      : clock, all logic on the rising edge
//   areset_n  : asynchronous active-low reset of the read pipeline (the
//               memory array itself is never reset)
//   bus       : slave side of the write/read bus (see the _if file)
// A read accepted at edge T is presented on read_valid/read_data for one
// cycle after edge T+READ_LATENCY-1; read_data holds between reads.
module logic_basic_queue_memory_pipelined #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int BYPASS        = 1
) (
  input  logic aclk,
  input  logic areset_n,
  logic_basic_queue_memory_pipelined_if.slave bus
);

  localparam int BYTES = (BYTE_WIDTH > 0) ? (DATA_WIDTH / BYTE_WIDTH) : 1;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  generate
    if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..4");
    end
    if (BYTE_WIDTH < 1) begin : g_bad_byte_width
      $error("BYTE_WIDTH must be at least 1");
    end else if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_data_width
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (($bits(bus.write_data) != DATA_WIDTH) ||
        ($bits(bus.write_pointer) != ADDRESS_WIDTH) ||
        ($bits(bus.write_byte_enable) != BYTES)) begin : g_bad_bus
      $error("interface parameters do not match the memory parameters");
    end
  endgenerate

  // Lanes whose mask bit is set come from new_word, the rest from old_word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]      mask
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (mask[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write process without reset so the array maps onto block RAM.
  // Writes are still suppressed while the reset is held.
  always_ff @(posedge aclk) begin
    if (areset_n && bus.write_enable) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.write_byte_enable[i]) begin
          mem[bus.write_pointer][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] old_word_p0;
  logic [DATA_WIDTH-1:0] rd_word_p0;
  logic                  collide_p0;

  // ---- stage 0: array read and optional bypass merge ----
  always_comb begin
    old_word_p0 = mem[bus.read_pointer];
    collide_p0  = bus.write_enable && (bus.write_pointer == bus.read_pointer);
    rd_word_p0  = old_word_p0;
    if ((BYPASS != 0) && collide_p0) begin
      rd_word_p0 = merge_lanes(old_word_p0, bus.write_data, bus.write_byte_enable);
    end
  end

  // Stage s of the read pipeline lives at index s; index READ_LATENCY drives
  // the outputs.
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] data_p;
  logic [READ_LATENCY:1]                 vld_p;

  // ---- stage 1 (RAM output register) and stages 2..READ_LATENCY ----
  // Each data register loads only with its incoming valid, so the final stage
  // keeps the last completed read when no new one arrives.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      vld_p  <= '0;
      data_p <= '0;
    end else begin
      vld_p[1] <= bus.read_enable;
      if (bus.read_enable) begin
        data_p[1] <= rd_word_p0;
      end
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) begin
          data_p[s] <= data_p[s-1];
        end
      end
    end
  end

  assign bus.read_valid = vld_p[READ_LATENCY];
  assign bus.read_data  = data_p[READ_LATENCY];

endmodule

// File: tb/tb_logic_basic_queue_memory_pipelined.sv
// Bench for logic_basic_queue_memory_pipelined. Three 16-bit builds run side
// by side on the same stimulus:
//   build 0 : READ_LATENCY=3, BYPASS=1
//   build 1 : READ_LATENCY=1, BYPASS=0
//   build 2 : READ_LATENCY=4, BYPASS=1
// A reference model (word array plus a list of pending responses, each due at
// a given edge) predicts read_valid/read_data of every build every cycle. A
// vector table adds directed same-cycle write/read cases with literal expected
// words, and short hand-written sequences cover reset and streaming.
module tb_logic_basic_queue_memory_pipelined;

  localparam int NDUT = 3;

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 4;
  endfunction

  function automatic int byp_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [1:0]  wbe;
  logic [3:0]  wp;
  logic [15:0] wd;
  logic        re;
  logic [3:0]  rp;

  logic [NDUT-1:0]       rv;
  logic [NDUT-1:0][15:0] rd;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      logic_basic_queue_memory_pipelined_if #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .BYTES(2)
      ) bus ();

      assign bus.write_enable      = we;
      assign bus.write_byte_enable = wbe;
      assign bus.write_pointer     = wp;
      assign bus.write_data        = wd;
      assign bus.read_enable       = re;
      assign bus.read_pointer      = rp;

      logic_basic_queue_memory_pipelined #(
        .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(lat_of(g)), .BYPASS(byp_of(g))
      ) dut (
        .aclk     (clk),
        .areset_n (rst_n),
        .bus      (bus)
      );

      assign rv[g] = bus.read_valid;
      assign rd[g] = bus.read_data;
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          dut;
    int          due;
    logic [15:0] data;
  } resp_t;

  logic [15:0] mdl_mem [16];
  resp_t       pend [$];
  logic [15:0] exp_last [NDUT];
  int          cyc;

  int errors;
  int checks;

  logic        collect;
  logic [15:0] strm_data [$];
  int          strm_cyc [$];

  task automatic check(input string name, input int d, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s build%0d cyc=%0d got=%h expected=%h", name, d, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    for (int d = 0; d < NDUT; d++) begin
      exp_v = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].dut == d && pend[i].due == cyc) begin
          exp_v       = 1'b1;
          exp_last[d] = pend[i].data;
          pend.delete(i);
        end
      end
      check("read_valid", d, {15'b0, rv[d]}, {15'b0, exp_v});
      check("read_data", d, rd[d], exp_last[d]);
    end
    if (collect && rv[2]) begin
      strm_data.push_back(rd[2]);
      strm_cyc.push_back(cyc);
    end
  endtask

  // Applies the currently driven inputs for one rising edge, then checks.
  task automatic tick();
    logic [15:0] old_w;
    logic [15:0] new_w;
    resp_t       r;
    if (rst_n === 1'b1) begin
      if (re) begin
        old_w = mdl_mem[rp];
        new_w = old_w;
        if (we && wp == rp) begin
          if (wbe[0]) new_w[7:0]  = wd[7:0];
          if (wbe[1]) new_w[15:8] = wd[15:8];
        end
        for (int d = 0; d < NDUT; d++) begin
          r.dut  = d;
          r.due  = cyc + lat_of(d);
          r.data = (byp_of(d) != 0) ? new_w : old_w;
          pend.push_back(r);
        end
      end
      if (we) begin
        if (wbe[0]) mdl_mem[wp][7:0]  = wd[7:0];
        if (wbe[1]) mdl_mem[wp][15:8] = wd[15:8];
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    pend.delete();
    for (int d = 0; d < NDUT; d++) exp_last[d] = '0;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    re = 1'b0;
    repeat (n) tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  mask;
    logic [3:0]  wp;
    logic [15:0] wd;
    logic [3:0]  rp;
    logic [15:0] exp_byp;
    logic [15:0] exp_nobyp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    collect = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_last[d] = '0;

    // Applied in order after memory holds value = address; each row writes
    // and reads in the same cycle, and the expected word accounts for all
    // earlier rows.
    vecs[0]  = '{1'b1, 2'b11, 4'd3,  16'h00A5, 4'd0,  16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 2'b11, 4'd7,  16'h1111, 4'd3,  16'h00A5, 16'h00A5};
    vecs[2]  = '{1'b1, 2'b10, 4'd7,  16'hABCD, 4'd7,  16'hAB11, 16'h1111};
    vecs[3]  = '{1'b1, 2'b00, 4'd0,  16'hFFFF, 4'd7,  16'hAB11, 16'hAB11};
    vecs[4]  = '{1'b1, 2'b11, 4'd5,  16'h1234, 4'd4,  16'h0004, 16'h0004};
    vecs[5]  = '{1'b1, 2'b01, 4'd5,  16'hABCD, 4'd5,  16'h12CD, 16'h1234};
    vecs[6]  = '{1'b1, 2'b00, 4'd5,  16'h5555, 4'd5,  16'h12CD, 16'h12CD};
    vecs[7]  = '{1'b1, 2'b01, 4'd9,  16'h00EE, 4'd9,  16'h00EE, 16'h0009};
    vecs[8]  = '{1'b1, 2'b11, 4'd9,  16'hBEEF, 4'd8,  16'h0008, 16'h0008};
    vecs[9]  = '{1'b1, 2'b10, 4'd15, 16'hC3FF, 4'd15, 16'hC30F, 16'h000F};
    vecs[10] = '{1'b1, 2'b00, 4'd9,  16'h0000, 4'd9,  16'hBEEF, 16'hBEEF};
    vecs[11] = '{1'b0, 2'b11, 4'd3,  16'hFFFF, 4'd3,  16'h00A5, 16'h00A5};

    // Reset held with both requests active: outputs stay zero.
    rst_n = 1'b0;
    we    = 1'b1;
    wbe   = 2'b11;
    wp    = 4'd3;
    wd    = 16'hFFFF;
    re    = 1'b1;
    rp    = 4'd3;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(1);

    // Fill value = address.
    we  = 1'b1;
    wbe = 2'b11;
    for (int a = 0; a < 16; a++) begin
      wp = 4'(a);
      wd = 16'(a);
      tick();
    end

    // Back-to-back reads of 0..15.
    we      = 1'b0;
    collect = 1'b1;
    re      = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rp = 4'(a);
      tick();
    end
    idle(6);
    collect = 1'b0;
    check("stream_count", 2, 16'(strm_data.size()), 16'd16);
    for (int i = 0; i < strm_data.size(); i++) begin
      check("stream_data", 2, strm_data[i], 16'(i));
      check("stream_gap", 2, 16'(strm_cyc[i] - strm_cyc[0]), 16'(i));
    end
    check("stream_hold_data", 2, rd[2], 16'h000F);
    check("stream_hold_valid", 2, {15'b0, rv[2]}, 16'h0000);

    // Table of same-cycle write/read cases.
    foreach (vecs[k]) begin
      we  = vecs[k].we;
      wbe = vecs[k].mask;
      wp  = vecs[k].wp;
      wd  = vecs[k].wd;
      re  = 1'b1;
      rp  = vecs[k].rp;
      tick();
      idle(5);
      for (int d = 0; d < NDUT; d++) begin
        check("table_word", d, rd[d],
              (byp_of(d) != 0) ? vecs[k].exp_byp : vecs[k].exp_nobyp);
      end
    end

    // Writes and reads presented during reset are ignored; memory survives.
    assert_reset();
    we  = 1'b1;
    wbe = 2'b11;
    wp  = 4'd3;
    wd  = 16'hFFFF;
    re  = 1'b1;
    rp  = 4'd3;
    repeat (3) tick();
    rst_n = 1'b1;
    we    = 1'b0;
    tick();
    idle(5);
    for (int d = 0; d < NDUT; d++) check("after_reset_word", d, rd[d], 16'h00A5);

    // Reset one cycle after a read on the latency-3 build kills it.
    re = 1'b1;
    rp = 4'd3;
    tick();
    idle(1);
    assert_reset();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("inflight_killed", 0, rd[0], 16'h0000);
    re = 1'b1;
    rp = 4'd3;
    tick();
    idle(5);
    check("inflight_reread", 0, rd[0], 16'h00A5);

    // Random traffic on a few addresses so collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        assert_reset();
        idle(1);
        rst_n = 1'b1;
      end
      we  = 1'($urandom_range(0, 1));
      wbe = 2'($urandom_range(0, 3));
      wp  = 4'($urandom_range(0, 3));
      wd  = 16'($urandom);
      re  = 1'($urandom_range(0, 1));
      rp  = 4'($urandom_range(0, 3));
      tick();
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_basic_queue_memory_pipelined.md
Name: logic_basic_queue_memory_pipelined

Overview:
Simple dual-port queue storage: one write port, one read port, one clock. It adds per-byte write enables, a configurable registered read latency with a matching read-valid pipeline, and optional read-during-write bypass. It is the storage element instantiated under queue/FIFO controllers that need deeper read pipelining or partial-word updates.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
ADDRESS_WIDTH, 4, pointer width; memory depth = 2**ADDRESS_WIDTH.
BYTE_WIDTH, 8, bits per write lane; lane count BYTES = DATA_WIDTH/BYTE_WIDTH.
READ_LATENCY, 1, cycles from an accepted read to read_valid/read_data; legal range 1..4.
BYPASS, 1, 1 = a same-cycle same-address read returns newly written lanes; 0 = it returns old contents.

Ports:
aclk  input  1  clock, all logic on rising edge
areset_n  input  1  reset, asynchronous, active-low
write_enable  input  1  write request this cycle
write_byte_enable  input  BYTES  per-lane write mask, bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH]
write_pointer  input  ADDRESS_WIDTH  write address
write_data  input  DATA_WIDTH  write word
read_enable  input  1  read request this cycle
read_pointer  input  ADDRESS_WIDTH  read address
read_valid  output  1  read_data carries a completed read this cycle
read_data  output  DATA_WIDTH  read word; holds last completed value otherwise

Behaviour:
- Reset: asynchronous assert on areset_n low, synchronous-safe deassert. While low: read_valid=0, read_data=0, all internal stage data=0, all stage valid bits=0. Memory array is not reset; it keeps its contents across reset. While areset_n is low, write_enable and read_enable are ignored.
- Write: on a rising edge with write_enable=1, for every lane i with write_byte_enable[i]=1, memory[write_pointer] lane i <= write_data lane i. Other lanes are unchanged. write_enable=1 with an all-zero mask is a no-op.
- Read: a read is accepted on a rising edge with read_enable=1. Stage 1 captures the word addressed by read_pointer together with valid=1. Stages 2..READ_LATENCY shift forward. read_valid and read_data are the final stage outputs, so a read accepted at edge T appears for exactly one cycle after edge T+READ_LATENCY-1. For example, with READ_LATENCY=1, the data is visible in the cycle immediately following the request.
- Data hold: each stage's data register loads only when its incoming valid is 1. read_data therefore holds the last completed read when read_valid=0.
- Throughput: one read and one write per cycle, sustained. Consecutive reads emerge in order on consecutive cycles with no bubbles. There is no backpressure; the consumer must accept every read_valid pulse.
- Read-during-write at the same address in the same cycle:
  - BYPASS=1: stage 1 captures a merged word. Lanes with write_byte_enable=1 take write_data; the other lanes take the old memory contents.
  - BYPASS=0: stage 1 captures the full old memory contents.
  - Different addresses never interact.
- Pointers: the full range 0..2**ADDRESS_WIDTH-1 is valid. There is no wrap or overflow logic; the caller owns pointer arithmetic.
- Reset mid-operation: all in-flight reads are discarded and no read_valid is produced for them. A write that has already completed before reset assertion stays in memory.
- Elaboration error if READ_LATENCY<1, READ_LATENCY>4, BYTE_WIDTH<1, or DATA_WIDTH%BYTE_WIDTH!=0.
- The memory array has no reset and uses a single write process, so it maps to block RAM. Stage 1 is the RAM output register; the bypass mux sits before stage 1.

Test Plan:
1. Reset check: drive areset_n=0 with read_enable=1 and write_enable=1 -> read_valid=0 and read_data=0 throughout. After release, read the addresses that were targeted during reset -> they show their pre-reset contents.
2. Latency: DATA_WIDTH=8, write 0xA5 to address 3, then read address 3 at edge T.
   - READ_LATENCY=1 -> read_valid=1, read_data=0xA5 in the cycle after T only.
   - READ_LATENCY=3 -> the same response appears 2 cycles later.
3. Byte enables: DATA_WIDTH=16, write 0x1234 with mask 2'b11, then 0xABCD with mask 2'b01, then read -> 0x12CD. A subsequent write with mask 2'b00 leaves the word at 0x12CD.
4. Bypass: address 7 holds 0x1111. In the same cycle, write 0xABCD with mask 2'b10 and read address 7.
   - BYPASS=1 -> 0xAB11.
   - BYPASS=0 -> 0x1111.
   - A following read -> 0xAB11 in both builds.
5. Streaming: fill addresses 0..15 with value = address, then issue reads of 0..15 on consecutive cycles, READ_LATENCY=4 -> 16 consecutive read_valid cycles carrying 0..15 in order, after which read_data holds 15 with read_valid=0.
6. Reset in flight: READ_LATENCY=3, read address 3 (holding 0xA5), then assert areset_n low one cycle later for 2 cycles -> read_valid never pulses for that read. Reading address 3 again after release returns 0xA5.
